morse_entry_ctrl: RTL and testbench

Sequencing controller for Morse letter entry. It conditions the raw Morse key and confirm button, times each key press, and classifies it as dot or dash. It assembles the element pattern into a letter code and writes each finished letter into the next of NUM_SLOTS display letter registers, which feed the 7-segment muxer. It owns the slot counter and the full/overflow policy.

---
 rtl/morse_pkg.sv | 12 +
 rtl/morse_debounce.sv | 38 +++
 rtl/morse_entry_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_morse_entry_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and element encodings for the Morse letter entry path.
package morse_pkg;

  typedef enum logic [2:0] {IDLE, PRESS, GAP, COMMIT, CLEAR} state_t;

  localparam logic [1:0] DOT_BITS  = 2'b10;
  localparam int         DOT_W     = 2;
  localparam logic [3:0] DASH_BITS = 4'b1110;
  localparam int         DASH_W    = 4;
  localparam int         SLOT_W    = 3;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw button.
module morse_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // level only moves after DEBOUNCE_CYC consecutive samples that disagree with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_entry_ctrl.sv
// Morse letter entry: times key presses, builds letter codes and writes them to display slots.
module morse_entry_ctrl
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int DASH_CYC     = 25_000_000,
  parameter int GAP_CYC      = 70_000_000,
  parameter int MAX_ELEM     = 4,
  parameter int NUM_SLOTS    = 5,
  parameter int CODE_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key,
  input  logic              confirm,
  input  logic              clr,
  output logic              wr_en,
  output logic [2:0]        wr_slot,
  output logic [CODE_W-1:0] wr_code,
  output logic [2:0]        elem_cnt,
  output logic              full,
  output logic              err
);

  localparam int PT_W = $clog2(DASH_CYC + 1);
  localparam int GT_W = $clog2(GAP_CYC + 1);

  function automatic logic [CODE_W-1:0] append_elem(input logic [CODE_W-1:0] c,
                                                    input logic dash);
    if (dash) return (c << DASH_W) | CODE_W'(DASH_BITS);
    else      return (c << DOT_W)  | CODE_W'(DOT_BITS);
  endfunction

  logic [1:0] rst_sync;
  logic       rst_s;
  logic       key_lvl, conf_lvl, key_prev, conf_prev;
  logic       key_rise, key_fall, conf_rise;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d, code_new, commit_code;
  logic [2:0]          elem_q, elem_d;
  logic [SLOT_W-1:0]   slot_q, slot_d, clr_idx_q, clr_idx_d;
  logic [PT_W-1:0]     ptmr_q, ptmr_d;
  logic [GT_W-1:0]     gtmr_q, gtmr_d;
  logic                pend_q, pend_d;
  logic                app_vld_p1, app_vld_d, app_dash_p1, app_dash_d;
  logic                wr_en_d, err_d, commit;
  logic [SLOT_W-1:0]   wr_slot_d;
  logic [CODE_W-1:0]   wr_code_d;

  // Assertion is immediate; release is aligned to the clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_s = rst_sync[1];

  morse_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_key (
    .clock(clock), .reset(rst_s), .din(key), .level(key_lvl)
  );
  morse_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_conf (
    .clock(clock), .reset(rst_s), .din(confirm), .level(conf_lvl)
  );

  assign key_rise  = key_lvl & ~key_prev;
  assign key_fall  = ~key_lvl & key_prev;
  assign conf_rise = conf_lvl & ~conf_prev;
  assign full      = (slot_q == SLOT_W'(NUM_SLOTS));
  assign elem_cnt  = elem_q;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    elem_d      = elem_q;
    slot_d      = slot_q;
    clr_idx_d   = clr_idx_q;
    ptmr_d      = ptmr_q;
    gtmr_d      = gtmr_q;
    pend_d      = pend_q;
    app_vld_d   = 1'b0;
    app_dash_d  = app_dash_p1;
    wr_en_d     = 1'b0;
    wr_slot_d   = '0;
    wr_code_d   = '0;
    err_d       = 1'b0;
    commit      = 1'b0;
    code_new    = append_elem(code_q, app_dash_p1);
    commit_code = code_q;

    if (clr) begin
      state_d   = CLEAR;
      slot_d    = '0;
      code_d    = '0;
      elem_d    = '0;
      pend_d    = 1'b0;
      wr_en_d   = 1'b1;
      clr_idx_d = SLOT_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (key_rise) begin
            state_d = PRESS;
            ptmr_d  = '0;
          end
        end
        PRESS: begin
          if (ptmr_q < PT_W'(DASH_CYC)) ptmr_d = ptmr_q + 1'b1;
          if (conf_rise) pend_d = 1'b1;
          if (key_fall) begin
            app_vld_d  = 1'b1;
            app_dash_d = (ptmr_q >= PT_W'(DASH_CYC));
            state_d    = GAP;
            gtmr_d     = '0;
          end
        end
        GAP: begin
          if (app_vld_p1) begin
            if (elem_q == 3'(MAX_ELEM)) begin
              err_d   = 1'b1;
              code_d  = '0;
              elem_d  = '0;
              pend_d  = 1'b0;
              state_d = IDLE;
            end else if (pend_q || conf_rise) begin
              commit      = 1'b1;
              commit_code = code_new;
            end else begin
              code_d = code_new;
              elem_d = elem_q + 3'd1;
              gtmr_d = gtmr_q + 1'b1;
            end
          end else if (key_rise) begin
            state_d = PRESS;
            ptmr_d  = '0;
          end else if (gtmr_q == GT_W'(GAP_CYC - 1) || conf_rise) begin
            commit = 1'b1;
          end else begin
            gtmr_d = gtmr_q + 1'b1;
          end
        end
        COMMIT: begin
          state_d = IDLE;
          if (key_rise) begin
            state_d = PRESS;
            ptmr_d  = '0;
          end
        end
        CLEAR: begin
          if (clr_idx_q == SLOT_W'(NUM_SLOTS)) begin
            state_d = IDLE;
          end else begin
            wr_en_d   = 1'b1;
            wr_slot_d = clr_idx_q;
            clr_idx_d = clr_idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // A full display drops the letter and flags it instead of writing
      if (commit) begin
        if (!full) begin
          wr_en_d   = 1'b1;
          wr_slot_d = slot_q;
          wr_code_d = commit_code;
          slot_d    = slot_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
        code_d  = '0;
        elem_d  = '0;
        pend_d  = 1'b0;
        state_d = COMMIT;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_s) begin
    if (!rst_s) begin
      state_q     <= IDLE;
      code_q      <= '0;
      elem_q      <= '0;
      slot_q      <= '0;
      clr_idx_q   <= '0;
      ptmr_q      <= '0;
      gtmr_q      <= '0;
      pend_q      <= 1'b0;
      app_vld_p1  <= 1'b0;
      app_dash_p1 <= 1'b0;
      key_prev    <= 1'b0;
      conf_prev   <= 1'b0;
      wr_en       <= 1'b0;
      wr_slot     <= '0;
      wr_code     <= '0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      elem_q      <= elem_d;
      slot_q      <= slot_d;
      clr_idx_q   <= clr_idx_d;
      ptmr_q      <= ptmr_d;
      gtmr_q      <= gtmr_d;
      pend_q      <= pend_d;
      app_vld_p1  <= app_vld_d;
      app_dash_p1 <= app_dash_d;
      key_prev    <= key_lvl;
      conf_prev   <= conf_lvl;
      wr_en       <= wr_en_d;
      wr_slot     <= wr_slot_d;
      wr_code     <= wr_code_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_entry_ctrl.sv
// Scoreboard bench for morse_entry_ctrl with short debounce/dash/gap timings.
module tb_morse_entry_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key = 1'b0;
  logic        confirm = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [15:0] wr_code;
  logic [2:0]  elem_cnt;
  logic        full;
  logic        err;

  typedef struct {
    logic        is_err;
    logic [2:0]  slot;
    logic [15:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  morse_entry_ctrl #(
    .DEBOUNCE_CYC(4), .DASH_CYC(20), .GAP_CYC(50),
    .MAX_ELEM(4), .NUM_SLOTS(5), .CODE_W(16)
  ) dut (
    .clock(clock), .reset(reset), .key(key), .confirm(confirm), .clr(clr),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_code(wr_code),
    .elem_cnt(elem_cnt), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every write or err pulse must match the oldest expected event
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (wr_en || err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual wr_en=%0b err=%0b slot=%0d code=%h required none",
                   wr_en, err, wr_slot, wr_code);
        end else begin
          e = exp_q.pop_front();
          if (wr_en !== !e.is_err || err !== e.is_err || wr_slot !== e.slot || wr_code !== e.code) begin
            errors++;
            $display("FAIL event actual wr_en=%0b err=%0b slot=%0d code=%h required wr_en=%0b err=%0b slot=%0d code=%h",
                     wr_en, err, wr_slot, wr_code, !e.is_err, e.is_err, e.slot, e.code);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_write(input int slot, input int code);
    ev_t e;
    e.is_err = 1'b0;
    e.slot   = 3'(slot);
    e.code   = 16'(code);
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.is_err = 1'b1;
    e.slot   = '0;
    e.code   = '0;
    exp_q.push_back(e);
  endtask

  task automatic press(input int len);
    key = 1'b1;
    tick(len);
    key = 1'b0;
  endtask

  task automatic conf();
    confirm = 1'b1;
    tick(8);
    confirm = 1'b0;
    tick(8);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    chk(name, exp_q.size(), 0);
    tick(5);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_elem_cnt", int'(elem_cnt), 0);
    chk("rst_wr_code", int'(wr_code), 0);
    reset = 1'b1;
    tick(5);

    // Single dot then confirm
    exp_write(0, 16'h0002);
    press(8); tick(10); conf();
    drain("t1_drain");

    // dot dash dot, auto commit after gap
    exp_write(1, 16'h00BA);
    press(8); tick(10); press(30); tick(10); press(8);
    tick(80);
    drain("t2_drain");
    chk("t2_elem_cnt", int'(elem_cnt), 0);

    // Five dashes overflow the letter
    exp_err();
    for (int i = 0; i < 5; i++) begin
      press(30); tick(10);
    end
    tick(20);
    drain("t4_drain");
    chk("t4_elem_cnt", int'(elem_cnt), 0);
    exp_write(2, 16'h0002);
    press(8); tick(10); conf();
    drain("t4_next_drain");

    // Glitch and empty confirm do nothing
    key = 1'b1; tick(2); key = 1'b0; tick(10);
    conf();
    tick(60);
    drain("t5_drain");
    chk("t5_elem_cnt", int'(elem_cnt), 0);

    // Reset mid-PRESS with one element already in the letter
    press(8); tick(10);
    key = 1'b1; tick(12);
    chk("mid_elem_cnt", int'(elem_cnt), 1);
    reset = 1'b0;
    #1;
    chk("midrst_elem_cnt", int'(elem_cnt), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_full", int'(full), 0);
    key = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(5);
    conf();
    tick(60);
    drain("midrst_drain");

    // Fill all five slots, sixth letter is dropped
    for (int i = 0; i < 5; i++) begin
      exp_write(i, 16'h0002);
      press(8); tick(10); conf();
      drain("fill_drain");
    end
    chk("fill_full", int'(full), 1);
    exp_err();
    press(8); tick(10); conf();
    drain("sixth_drain");
    chk("sixth_full", int'(full), 1);

    // Clear burst blanks every slot
    for (int i = 0; i < 5; i++) exp_write(i, 16'h0000);
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(10);
    drain("clr_drain");
    chk("clr_full", int'(full), 0);
    chk("clr_elem_cnt", int'(elem_cnt), 0);

    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
